// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states, command layout.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] ADD = 3'd0;
  localparam logic [OP_W-1:0] SUB = 3'd1;
  localparam logic [OP_W-1:0] AND = 3'd2;
  localparam logic [OP_W-1:0] OR  = 3'd3;
  localparam logic [OP_W-1:0] NOT = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Reference layout of one queued command at the default operand width.
  localparam int CMD_DATA_W = 8;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [CMD_DATA_W-1:0] a;
    logic [CMD_DATA_W-1:0] b;
    logic                  use_acc;
  } cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO with registered storage; read data is the entry at the read pointer.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wr_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// ALU command sequencer: queues commands, drives registered ALU operands, returns results.
// Optional accumulator operand enabled by defining ALU_SEQ_ACCUM_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

`ifdef ALU_SEQ_ACCUM_EN
  localparam int ENTRY_W = OP_W + 2*DATA_W + 1;
`else
  localparam int ENTRY_W = OP_W + 2*DATA_W;
`endif

  state_t                      state;
  state_t                      state_n;
  logic                        pop;
  logic                        capture;
  logic                        push;
  logic [ENTRY_W-1:0]          wr_data;
  logic [ENTRY_W-1:0]          rd_data;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [OP_W-1:0]             ent_op;
  logic [DATA_W-1:0]           ent_a;
  logic [DATA_W-1:0]           ent_b;
  logic [DATA_W-1:0]           load_a;

  assign cmd_ready = rst_n && !full;
  assign push      = cmd_valid && cmd_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || (fifo_count != '0);

  assign ent_op = rd_data[ENTRY_W-1 -: OP_W];
  assign ent_a  = rd_data[ENTRY_W-OP_W-1 -: DATA_W];
  assign ent_b  = rd_data[ENTRY_W-OP_W-DATA_W-1 -: DATA_W];

`ifdef ALU_SEQ_ACCUM_EN
  logic [DATA_W-1:0] acc;
  assign wr_data = {cmd_op, cmd_a, cmd_b, cmd_use_acc};
  assign load_a  = rd_data[0] ? acc : ent_a;

  // Updated on the EXEC capture, so a back-to-back pop already sees the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      acc <= '0;
    else if (capture && alu_op <= NOT) acc <= alu_result;
  end
`else
  logic unused_use_acc;
  assign unused_use_acc = cmd_use_acc;
  assign wr_data = {cmd_op, cmd_a, cmd_b};
  assign load_a  = ent_a;
`endif

  alu_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = EXEC;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (pop) begin
        alu_a  <= load_a;
        alu_b  <= ent_b;
        alu_op <= ent_op;
      end
      // Illegal opcodes still go through the ALU; only the error flag marks them.
      if (capture) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= (alu_op > NOT);
      end
    end
  end

endmodule
